// File: rtl/mic_frame_scheduler.sv
// Buffers stereo mic frames, feeds them left-then-right into one shared filter
// datapath, and re-pairs the tagged filter results into stereo output frames.
module mic_frame_scheduler #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic                   clock_in,
    input  logic                   reset_n_in,
    input  logic                   enable_in,
    input  logic [WIDTH-1:0]       left_sample_in,
    input  logic [WIDTH-1:0]       right_sample_in,
    input  logic                   new_sample_in,
    output logic [WIDTH-1:0]       sample_out,
    output logic                   channel_out,
    output logic                   valid_out,
    input  logic                   ready_in,
    input  logic [WIDTH-1:0]       result_in,
    input  logic                   result_channel_in,
    input  logic                   result_valid_in,
    output logic [WIDTH-1:0]       left_result_out,
    output logic [WIDTH-1:0]       right_result_out,
    output logic                   pair_valid_out,
    output logic [$clog2(DEPTH):0] fifo_count_out,
    output logic [CNT_W-1:0]       overflow_count_out,
    output logic                   order_error_out
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, SEND_L, SEND_R} state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [2*WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   w_rd_next;
    logic [PTR_W:0]     r_count;
    logic [CNT_W-1:0]   r_ovf;
    logic [WIDTH-1:0]   r_sample;
    logic [WIDTH-1:0]   w_sample_next;
    logic               w_valid;
    logic               w_channel;
    logic               w_pop;
    logic               w_full;
    logic               w_push;
    logic               w_drop;

    logic [WIDTH-1:0]   r_left;
    logic [WIDTH-1:0]   r_right;
    logic               r_left_vld;
    logic               r_right_vld;
    logic               r_order_err;
    logic               w_pair;

    assign w_rd_next = r_rd_ptr + 1'b1;
    assign w_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign w_pop     = (r_state == SEND_R) && ready_in;
    // A full FIFO still accepts a frame when the head leaves in the same cycle.
    assign w_push    = new_sample_in && (!w_full || w_pop);
    assign w_drop    = new_sample_in && w_full && !w_pop;

    always_ff @(posedge clock_in) begin
        if (w_push) r_mem[r_wr_ptr] <= {left_sample_in, right_sample_in};
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= '0;
            r_sample <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= w_rd_next;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop && (r_ovf != '1)) r_ovf <= r_ovf + 1'b1;
            r_sample <= w_sample_next;
        end
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) r_state <= IDLE;
        else             r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (enable_in && (r_count != '0)) w_next_state = SEND_L;
            SEND_L:  if (ready_in) w_next_state = SEND_R;
            SEND_R:  if (ready_in) w_next_state = (enable_in && (r_count > (PTR_W+1)'(1))) ? SEND_L : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Output register only reloads on a state change, so it holds under backpressure.
    always_comb begin
        w_valid       = 1'b0;
        w_channel     = 1'b0;
        w_sample_next = r_sample;
        case (r_state)
            IDLE: begin
                if (w_next_state == SEND_L) w_sample_next = r_mem[r_rd_ptr][2*WIDTH-1:WIDTH];
            end
            SEND_L: begin
                w_valid = 1'b1;
                if (ready_in) w_sample_next = r_mem[r_rd_ptr][WIDTH-1:0];
            end
            SEND_R: begin
                w_valid   = 1'b1;
                w_channel = 1'b1;
                if (w_next_state == SEND_L) w_sample_next = r_mem[w_rd_next][2*WIDTH-1:WIDTH];
            end
            default: begin
                w_valid   = 1'b0;
                w_channel = 1'b0;
            end
        endcase
    end

    assign w_pair = r_left_vld && r_right_vld;

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_left      <= '0;
            r_right     <= '0;
            r_left_vld  <= 1'b0;
            r_right_vld <= 1'b0;
            r_order_err <= 1'b0;
        end else begin
            if (w_pair) begin
                r_left_vld  <= 1'b0;
                r_right_vld <= 1'b0;
            end
            // A result landing on the pulse cycle opens the next pair rather than colliding.
            if (result_valid_in) begin
                if (result_channel_in) begin
                    r_right     <= result_in;
                    r_right_vld <= 1'b1;
                    if (r_right_vld && !w_pair) r_order_err <= 1'b1;
                end else begin
                    r_left      <= result_in;
                    r_left_vld  <= 1'b1;
                    if (r_left_vld && !w_pair) r_order_err <= 1'b1;
                end
            end
        end
    end

    assign sample_out         = r_sample;
    assign channel_out        = w_channel;
    assign valid_out          = w_valid;
    assign fifo_count_out     = r_count;
    assign overflow_count_out = r_ovf;
    assign left_result_out    = r_left;
    assign right_result_out   = r_right;
    assign pair_valid_out     = w_pair;
    assign order_error_out    = r_order_err;

endmodule

// File: tb/tb_mic_frame_scheduler.sv
// Scoreboard bench for mic_frame_scheduler: a frame-queue reference model predicts
// the handshake stream and result pairs; a negedge monitor pops and compares.
module tb_mic_frame_scheduler;

    localparam int DEPTH = 4;
    localparam int WIDTH = 16;
    localparam int CNT_W = 8;

    logic             clock_in = 1'b0;
    logic             reset_n_in = 1'b0;
    logic             enable_in = 1'b0;
    logic [WIDTH-1:0] left_sample_in = '0;
    logic [WIDTH-1:0] right_sample_in = '0;
    logic             new_sample_in = 1'b0;
    logic             ready_in = 1'b0;
    logic [WIDTH-1:0] result_in = '0;
    logic             result_channel_in = 1'b0;
    logic             result_valid_in = 1'b0;
    logic [WIDTH-1:0] sample_out;
    logic             channel_out;
    logic             valid_out;
    logic [WIDTH-1:0] left_result_out;
    logic [WIDTH-1:0] right_result_out;
    logic             pair_valid_out;
    logic [$clog2(DEPTH):0] fifo_count_out;
    logic [CNT_W-1:0] overflow_count_out;
    logic             order_error_out;

    mic_frame_scheduler #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clock_in(clock_in), .reset_n_in(reset_n_in), .enable_in(enable_in),
        .left_sample_in(left_sample_in), .right_sample_in(right_sample_in),
        .new_sample_in(new_sample_in), .sample_out(sample_out), .channel_out(channel_out),
        .valid_out(valid_out), .ready_in(ready_in), .result_in(result_in),
        .result_channel_in(result_channel_in), .result_valid_in(result_valid_in),
        .left_result_out(left_result_out), .right_result_out(right_result_out),
        .pair_valid_out(pair_valid_out), .fifo_count_out(fifo_count_out),
        .overflow_count_out(overflow_count_out), .order_error_out(order_error_out)
    );

    always #5 clock_in = ~clock_in;

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_on = 1'b0;

    // Reference model: stored frames, which half of the head frame is on offer, result pairing.
    logic [31:0] m_q [$];
    int          m_ph;
    int          m_ovf;
    bit          m_err, m_lv, m_rv;
    logic [15:0] m_l, m_r;
    logic [16:0] exp_q [$];
    logic [31:0] pair_q [$];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        exp_q.delete();
        pair_q.delete();
        m_ph = 0; m_ovf = 0;
        m_err = 0; m_lv = 0; m_rv = 0;
        m_l = '0; m_r = '0;
    endtask

    task automatic model_step();
        int pre;
        bit hs, pop, pairing;
        pre = m_q.size();
        hs  = (m_ph != 0) && ready_in;
        pop = hs && (m_ph == 2);
        if (m_ph == 0) begin
            if (enable_in && pre > 0) m_ph = 1;
        end else if (hs) begin
            m_ph = (m_ph == 1) ? 2 : ((enable_in && pre > 1) ? 1 : 0);
        end
        if (pop) void'(m_q.pop_front());
        if (new_sample_in) begin
            if (pre < DEPTH || pop) begin
                m_q.push_back({left_sample_in, right_sample_in});
                exp_q.push_back({1'b0, left_sample_in});
                exp_q.push_back({1'b1, right_sample_in});
            end else if (m_ovf < 255) begin
                m_ovf++;
            end
        end
        pairing = m_lv && m_rv;
        if (pairing) begin m_lv = 0; m_rv = 0; end
        if (result_valid_in) begin
            if (!result_channel_in) begin
                if (m_lv) m_err = 1;
                m_l = result_in; m_lv = 1;
            end else begin
                if (m_rv) m_err = 1;
                m_r = result_in; m_rv = 1;
            end
        end
        if (m_lv && m_rv) pair_q.push_back({m_l, m_r});
    endtask

    task automatic tick();
        @(posedge clock_in);
        if (reset_n_in) model_step();
        #1;
        new_sample_in   = 1'b0;
        result_valid_in = 1'b0;
    endtask

    task automatic push_frame(input logic [15:0] l, input logic [15:0] r);
        new_sample_in   = 1'b1;
        left_sample_in  = l;
        right_sample_in = r;
    endtask

    task automatic give_result(input logic ch, input logic [15:0] d);
        result_valid_in   = 1'b1;
        result_channel_in = ch;
        result_in         = d;
    endtask

    always @(negedge clock_in) begin : monitor
        logic [16:0] e;
        logic [31:0] p;
        if (mon_on && reset_n_in) begin
            chk("valid_out", valid_out, m_ph != 0);
            chk("fifo_count", fifo_count_out, m_q.size());
            chk("overflow_count", overflow_count_out, m_ovf);
            chk("order_error", order_error_out, m_err);
            chk("pair_valid", pair_valid_out, m_lv && m_rv);
            if (valid_out && ready_in) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL handshake: got sample 0x%0h ch %0d, expected none at %0t", sample_out, channel_out, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("hs_sample", sample_out, e[15:0]);
                    chk("hs_channel", channel_out, e[16]);
                end
            end
            if (pair_valid_out) begin
                if (pair_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL pair: got L 0x%0h R 0x%0h, expected none at %0t", left_result_out, right_result_out, $time);
                end else begin
                    p = pair_q.pop_front();
                    chk("pair_left", left_result_out, p[31:16]);
                    chk("pair_right", right_result_out, p[15:0]);
                end
            end
        end
    end

    initial begin
        logic [15:0] held;
        model_reset();
        #2;
        chk("rst_valid", valid_out, 0);
        chk("rst_sample", sample_out, 0);
        chk("rst_channel", channel_out, 0);
        chk("rst_count", fifo_count_out, 0);
        chk("rst_overflow", overflow_count_out, 0);
        chk("rst_pair", pair_valid_out, 0);
        chk("rst_order_err", order_error_out, 0);
        repeat (3) tick();
        reset_n_in = 1'b1;
        enable_in  = 1'b1;
        ready_in   = 1'b1;
        mon_on     = 1'b1;

        // single frame, latency 2
        push_frame(16'h1234, 16'hFFFB);
        tick();
        chk("t1_not_yet", valid_out, 0);
        tick();
        chk("t1_valid_l", valid_out, 1);
        chk("t1_sample_l", sample_out, 16'h1234);
        chk("t1_chan_l", channel_out, 0);
        tick();
        chk("t1_sample_r", sample_out, 16'hFFFB);
        chk("t1_chan_r", channel_out, 1);
        tick();
        chk("t1_idle", valid_out, 0);
        chk("t1_count", fifo_count_out, 0);

        // backpressure in SEND_L
        ready_in = 1'b0;
        push_frame(16'hA5A5, 16'h5A5A);
        tick();
        tick();
        held = sample_out;
        chk("t2_held_val", held, 16'hA5A5);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_hold_valid", valid_out, 1);
            chk("t2_hold_sample", sample_out, held);
            chk("t2_hold_chan", channel_out, 0);
            chk("t2_hold_count", fifo_count_out, 1);
        end
        ready_in = 1'b1;
        tick();
        chk("t2_resume_r", sample_out, 16'h5A5A);
        chk("t2_resume_ch", channel_out, 1);
        tick();
        chk("t2_done", valid_out, 0);

        // overflow: six pushes into four slots
        ready_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push_frame(16'h1000 + 16'(i), 16'h2000 + 16'(i));
            tick();
        end
        chk("t3_count", fifo_count_out, 4);
        chk("t3_overflow", overflow_count_out, 2);
        ready_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t3_b2b_valid", valid_out, 1);
            chk("t3_b2b_sample", sample_out, (i % 2 == 0) ? 16'h1000 + 16'(i/2) : 16'h2000 + 16'(i/2));
            chk("t3_b2b_chan", channel_out, i % 2);
            tick();
        end
        chk("t3_drained", valid_out, 0);
        chk("t3_count0", fifo_count_out, 0);

        // full FIFO with push on the popping SEND_R handshake
        ready_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_frame(16'h3000 + 16'(i), 16'h4000 + 16'(i));
            tick();
        end
        ready_in = 1'b1;
        tick();
        chk("t4_in_send_r", channel_out, 1);
        push_frame(16'h3004, 16'h4004);
        tick();
        chk("t4_count", fifo_count_out, 4);
        chk("t4_overflow", overflow_count_out, 2);
        repeat (12) tick();
        chk("t4_count0", fifo_count_out, 0);

        // result pairing and ordering error
        give_result(1'b0, 16'd100);
        tick();
        tick();
        give_result(1'b1, 16'd200);
        tick();
        chk("t5_pair", pair_valid_out, 1);
        chk("t5_left", left_result_out, 100);
        chk("t5_right", right_result_out, 200);
        tick();
        chk("t5_pulse_end", pair_valid_out, 0);
        chk("t5_no_err", order_error_out, 0);
        give_result(1'b0, 16'd300);
        tick();
        give_result(1'b0, 16'd400);
        tick();
        chk("t5_err", order_error_out, 1);
        chk("t5_left_over", left_result_out, 400);

        // reset while in SEND_R with 3 frames queued and a pair pulsing
        ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_frame(16'h5000 + 16'(i), 16'h6000 + 16'(i));
            tick();
        end
        ready_in = 1'b1;
        give_result(1'b1, 16'd500);
        tick();
        ready_in = 1'b0;
        chk("t6_pre_chan", channel_out, 1);
        chk("t6_pre_count", fifo_count_out, 3);
        chk("t6_pre_pair", pair_valid_out, 1);
        #2;
        reset_n_in = 1'b0;
        model_reset();
        #1;
        chk("t6_valid", valid_out, 0);
        chk("t6_count", fifo_count_out, 0);
        chk("t6_pair", pair_valid_out, 0);
        chk("t6_overflow", overflow_count_out, 0);
        chk("t6_order_err", order_error_out, 0);
        tick();
        tick();
        reset_n_in = 1'b1;
        enable_in  = 1'b1;
        ready_in   = 1'b1;
        tick();
        chk("t6_idle", valid_out, 0);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            enable_in = ($urandom_range(0, 9) != 0);
            ready_in  = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 3) == 0) push_frame(16'($urandom), 16'($urandom));
            if ($urandom_range(0, 2) == 0) give_result(1'($urandom_range(0, 1)), 16'($urandom));
            tick();
        end
        enable_in = 1'b1;
        ready_in  = 1'b1;
        repeat (20) tick();
        chk("drain_handshakes", exp_q.size(), 0);
        chk("drain_pairs", pair_q.size(), 0);

        mon_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
